// File: rtl/bufg_switch_ctrl_pkg.sv
// Shared clocking package for the global clock mux sequencer.
//
// Holds the sequencer state encoding, the number of heartbeat activity
// events that count as "this clock is running", and a small helper used
// to size the shared cycle counter.
//
// Optional feature macro used by the importing RTL: BUFG_SWITCH_ALIVE_EN.
package bufg_switch_ctrl_pkg;

   // Sequencer states, in the order a full switch walks through them
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      DROP  = 3'd2,
      ARM   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Activity events needed before a heartbeat is trusted as alive
   localparam int ACT_EVENTS = 2;

   // Largest of three cycle limits; one counter serves every timed state
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/bufg_switch_ctrl_hb.sv
// hb_activity_det: heartbeat activity detector.
//
// Brings a toggling heartbeat from a foreign clock domain into clk through
// a 2-flop synchronizer, then compares the synchronized level with its
// previous value. Every change of level is one activity event.
//
// Ports:
//   clk  - control clock
//   rst  - asynchronous active-high reset
//   hb   - heartbeat, asynchronous to clk
//   evt  - one-cycle activity event in the clk domain
module hb_activity_det (
   input  logic clk,
   input  logic rst,
   input  logic hb,
   output logic evt
);

   logic [2:0] sync_q;

   // sync_q[0..1] form the synchronizer; sync_q[2] is the previous
   // synchronized level used by the edge detector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], hb};
      end
   end

   // Both inputs of the XOR are flop outputs in the clk domain
   assign evt = sync_q[2] ^ sync_q[1];

endmodule

// File: rtl/bufg_switch_ctrl.sv
// bufg_switch_ctrl: control-clock sequencer for a two-input glitch-free
// global clock mux.
//
// Drives the mux select, clock-enable and ignore inputs so that a switch
// always deselects the current clock before selecting the target clock.
// With BUFG_SWITCH_ALIVE_EN defined, the target heartbeat must show
// activity within ALIVE_WINDOW cycles or the request is rejected with err;
// without it the request goes straight to deselection and err stays 0.
//
// Parameters:
//   INIT_SEL      - clock selected out of reset (0 or 1)
//   ALIVE_WINDOW  - cycles allowed to see target heartbeat activity
//   DROP_TIMEOUT  - cycles to wait for the current clock to go quiet
//                   normally before forcing its ignore input
//   SETTLE_CYCLES - cycles the new selection is held before completion
//
// Ports:
//   clk, rst            - control clock, asynchronous active-high reset
//   sel_req, sel        - single-cycle switch request and target index
//   hb0, hb1            - heartbeats from the clock-0/clock-1 domains
//   s0, s1              - mux select inputs
//   ce0, ce1            - mux clock enables
//   ignore0, ignore1    - mux ignore inputs
//   cur_sel             - committed clock index
//   busy                - switch in progress
//   done                - one-cycle pulse when a request completes
//   err                 - one-cycle pulse when a dead target is rejected
//
// Optional feature macro: BUFG_SWITCH_ALIVE_EN.
module bufg_switch_ctrl #(
   parameter int INIT_SEL      = 0,
   parameter int ALIVE_WINDOW  = 32,
   parameter int DROP_TIMEOUT  = 64,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic sel_req,
   input  logic sel,
   input  logic hb0,
   input  logic hb1,
   output logic s0,
   output logic s1,
   output logic ce0,
   output logic ce1,
   output logic ignore0,
   output logic ignore1,
   output logic cur_sel,
   output logic busy,
   output logic done,
   output logic err
);

   import bufg_switch_ctrl_pkg::*;

   localparam int CNT_MAX = max3(ALIVE_WINDOW, DROP_TIMEOUT, SETTLE_CYCLES);
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int EW      = $clog2(ACT_EVENTS + 1);

   localparam logic       INIT_BIT    = (INIT_SEL != 0);
   localparam logic [1:0] INIT_ONEHOT = INIT_BIT ? 2'b10 : 2'b01;

   localparam logic [CW-1:0] CNT_SAT    = '1;
   localparam logic [CW-1:0] DROP_LIM   = CW'(DROP_TIMEOUT);
   localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYCLES);
   localparam logic [EW-1:0] EV_SAT     = '1;
   localparam logic [EW-1:0] EV_LIM     = EW'(ACT_EVENTS);
`ifdef BUFG_SWITCH_ALIVE_EN
   localparam logic [CW-1:0] ALIVE_LIM  = CW'(ALIVE_WINDOW);
`endif

   state_t        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
   logic [EW-1:0] ev_q, ev_n, ev_inc;
   logic          tgt_q, tgt_n;
   logic          cur_q, cur_n;
   logic [1:0]    s_q, s_n;
   logic [1:0]    ce_q, ce_n;
   logic [1:0]    ign_q, ign_n;
   logic          busy_q, busy_n;
   logic          done_q, done_n;
`ifdef BUFG_SWITCH_ALIVE_EN
   logic          err_q, err_n;
`endif
   logic [1:0]    evt;
   logic          evt_sel;

   hb_activity_det u_hb0 (
      .clk (clk),
      .rst (rst),
      .hb  (hb0),
      .evt (evt[0])
   );

   hb_activity_det u_hb1 (
      .clk (clk),
      .rst (rst),
      .hb  (hb1),
      .evt (evt[1])
   );

   // CHECK watches the target heartbeat; DROP watches the clock being released
`ifdef BUFG_SWITCH_ALIVE_EN
   assign evt_sel = (state_q == CHECK) ? evt[tgt_q] : evt[cur_q];
`else
   assign evt_sel = evt[cur_q];
`endif

   // Both counters stop at all-ones rather than wrapping back to zero
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
   assign ev_inc  = (ev_q == EV_SAT)   ? ev_q  : ev_q + EW'(evt_sel);

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ev_q    <= '0;
         tgt_q   <= INIT_BIT;
         cur_q   <= INIT_BIT;
         s_q     <= INIT_ONEHOT;
         ce_q    <= INIT_ONEHOT;
         ign_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef BUFG_SWITCH_ALIVE_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         ev_q    <= ev_n;
         tgt_q   <= tgt_n;
         cur_q   <= cur_n;
         s_q     <= s_n;
         ce_q    <= ce_n;
         ign_q   <= ign_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
`ifdef BUFG_SWITCH_ALIVE_EN
         err_q   <= err_n;
`endif
      end
   end

   // Next-state logic. Mux controls change only on state transitions, so
   // the deselect of the current clock (entering DROP) always lands at
   // least one cycle before the select of the target (entering ARM).
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      ev_n    = ev_q;
      tgt_n   = tgt_q;
      cur_n   = cur_q;
      s_n     = s_q;
      ce_n    = ce_q;
      ign_n   = ign_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
`ifdef BUFG_SWITCH_ALIVE_EN
      err_n   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            cnt_n  = '0;
            ev_n   = '0;
            busy_n = 1'b0;
            if (sel_req) begin
               if (sel == cur_q) begin
                  done_n = 1'b1;
               end else begin
                  tgt_n  = sel;
                  busy_n = 1'b1;
`ifdef BUFG_SWITCH_ALIVE_EN
                  state_n = CHECK;
`else
                  state_n        = DROP;
                  s_n[cur_q]     = 1'b0;
                  ce_n[cur_q]    = 1'b0;
`endif
               end
            end
         end

`ifdef BUFG_SWITCH_ALIVE_EN
         CHECK: begin
            cnt_n = cnt_inc;
            ev_n  = ev_inc;
            if (ev_inc >= EV_LIM) begin
               state_n     = DROP;
               cnt_n       = '0;
               ev_n        = '0;
               s_n[cur_q]  = 1'b0;
               ce_n[cur_q] = 1'b0;
            end else if (cnt_inc >= ALIVE_LIM) begin
               state_n = IDLE;
               cnt_n   = '0;
               ev_n    = '0;
               busy_n  = 1'b0;
               err_n   = 1'b1;
            end
         end
`endif

         DROP: begin
            cnt_n = cnt_inc;
            ev_n  = ev_inc;
            if (ev_inc >= EV_LIM || cnt_inc >= DROP_LIM) begin
               state_n     = ARM;
               cnt_n       = '0;
               ev_n        = '0;
               s_n[tgt_q]  = 1'b1;
               ce_n[tgt_q] = 1'b1;
               // The old clock never confirmed it let go: force the mux past it
               if (ev_inc < EV_LIM) begin
                  ign_n[cur_q] = 1'b1;
               end
            end
         end

         ARM: begin
            cnt_n = cnt_inc;
            if (cnt_inc >= SETTLE_LIM) begin
               state_n = DONE;
               cnt_n   = '0;
               cur_n   = tgt_q;
               ign_n   = '0;
            end
         end

         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign s0      = s_q[0];
   assign s1      = s_q[1];
   assign ce0     = ce_q[0];
   assign ce1     = ce_q[1];
   assign ignore0 = ign_q[0];
   assign ignore1 = ign_q[1];
   assign cur_sel = cur_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef BUFG_SWITCH_ALIVE_EN
   assign err     = err_q;
`else
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bufg_switch_ctrl.sv
// Testbench for bufg_switch_ctrl.
//
// Runs a table of switch requests with hand-computed outcomes, then a few
// hand-written multi-cycle sequences: a request arriving while busy, the
// current heartbeat stopping so ignore must be forced, and reset in ARM.
// Expected outcomes for a dead target depend on BUFG_SWITCH_ALIVE_EN.
module tb_bufg_switch_ctrl;

   localparam int W = 16;
   localparam int T = 20;
   localparam int S = 4;

   logic clk, rst, sel_req, sel, hb0, hb1;
   logic s0, s1, ce0, ce1, ignore0, ignore1, cur_sel, busy, done, err;

   logic hb0Run, hb1Run;
   int   checks, failures;
   int   overlapS, overlapCe, doneCount, errCount, busyCycles;
   logic ign0Seen, ign1Seen, firstBusy;

   typedef struct {
      logic sel;
      logic run0;
      logic run1;
      int   expDone;
      int   expErr;
      int   expCur;
      int   expIgn0;
      int   expIgn1;
      int   expBusy1;
      int   expBusyCycles;
   } vec_t;

   vec_t vecs[6];

   bufg_switch_ctrl #(
      .INIT_SEL      (1),
      .ALIVE_WINDOW  (W),
      .DROP_TIMEOUT  (T),
      .SETTLE_CYCLES (S)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sel_req (sel_req),
      .sel     (sel),
      .hb0     (hb0),
      .hb1     (hb1),
      .s0      (s0),
      .s1      (s1),
      .ce0     (ce0),
      .ce1     (ce1),
      .ignore0 (ignore0),
      .ignore1 (ignore1),
      .cur_sel (cur_sel),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   // Control clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Heartbeats slower than clk so every toggle becomes one event
   initial begin
      hb0 = 1'b0;
      forever begin
         #13;
         if (hb0Run) hb0 = ~hb0;
      end
   end

   initial begin
      hb1 = 1'b0;
      forever begin
         #17;
         if (hb1Run) hb1 = ~hb1;
      end
   end

   // Running observations of the mux controls and status pulses
   always @(negedge clk) begin
      if (s0 && s1)   overlapS++;
      if (ce0 && ce1) overlapCe++;
      if (done)       doneCount++;
      if (err)        errCount++;
      if (busy)       busyCycles++;
      if (ignore0)    ign0Seen = 1'b1;
      if (ignore1)    ign1Seen = 1'b1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [9:0] outVec();
      return {s1, s0, ce1, ce0, ignore1, ignore0, cur_sel, busy, done, err};
   endfunction

   // Clears per-request observations, then issues a one-cycle request
   task automatic applyStimulus(input logic target);
      @(negedge clk);
      #1;
      doneCount  = 0;
      errCount   = 0;
      busyCycles = 0;
      ign0Seen   = 1'b0;
      ign1Seen   = 1'b0;
      sel_req    = 1'b1;
      sel        = target;
      @(negedge clk);
      sel_req    = 1'b0;
      #1;
      firstBusy  = busy;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while (!((doneCount + errCount) > 0 && !busy) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput({name, "_finished"}, int'(n < 300), 1);
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n, t, d;
      string nm;

      checks = 0; failures = 0;
      overlapS = 0; overlapCe = 0; doneCount = 0; errCount = 0; busyCycles = 0;
      ign0Seen = 1'b0; ign1Seen = 1'b0; firstBusy = 1'b0;
      rst = 1'b1; sel_req = 1'b0; sel = 1'b0;
      hb0Run = 1'b1; hb1Run = 1'b1;

      //                sel  r0    r1    done err cur i0 i1 b1 busyCycles
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1,   0,  1,  0, 0, 0, 0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1,   0,  0,  0, 0, 1, -1};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1,   0,  0,  0, 0, 0, 0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1,   0,  1,  0, 0, 1, -1};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1,   0,  0,  0, 1, 1, -1};
`ifdef BUFG_SWITCH_ALIVE_EN
      vecs[5] = '{1'b1, 1'b1, 1'b0, 0,   1,  0,  0, 0, 1, W};
`else
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1,   0,  1,  0, 0, 1, -1};
`endif

      // Reset values with INIT_SEL = 1
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_outputs", int'(outVec()), int'(10'b1010001000));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         hb0Run = vecs[i].run0;
         hb1Run = vecs[i].run1;
         repeat (6) @(negedge clk);
         applyStimulus(vecs[i].sel);
         nm = $sformatf("vec%0d", i);
         waitIdle(nm);
         checkOutput({nm, "_busy_first"}, int'(firstBusy), vecs[i].expBusy1);
         checkOutput({nm, "_done"}, doneCount, vecs[i].expDone);
         checkOutput({nm, "_err"}, errCount, vecs[i].expErr);
         checkOutput({nm, "_cur_sel"}, int'(cur_sel), vecs[i].expCur);
         checkOutput({nm, "_ign0_seen"}, int'(ign0Seen), vecs[i].expIgn0);
         checkOutput({nm, "_ign1_seen"}, int'(ign1Seen), vecs[i].expIgn1);
         if (vecs[i].expBusyCycles >= 0)
            checkOutput({nm, "_busy_cycles"}, busyCycles, vecs[i].expBusyCycles);
      end

      // Second request while busy is dropped: one done, target unchanged
      hb0Run = 1'b1; hb1Run = 1'b1;
      doReset();
      repeat (6) @(negedge clk);
      applyStimulus(1'b0);
      @(negedge clk);
      sel_req = 1'b1; sel = 1'b1;
      @(negedge clk);
      sel_req = 1'b0;
      #1;
      waitIdle("busy_drop");
      repeat (60) @(negedge clk);
      #1;
      checkOutput("busy_drop_done_count", doneCount, 1);
      checkOutput("busy_drop_cur_sel", int'(cur_sel), 0);
      checkOutput("busy_drop_idle", int'(busy), 0);

      // Current heartbeat dead: ignore0 forced after DROP_TIMEOUT cycles
      hb0Run = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(1'b1);
      n = 0;
      while (s0 && n < 200) begin @(negedge clk); #1; n++; end
      checkOutput("stop_s0_dropped", int'(s0), 0);
      t = 0;
      while (!ignore0 && t < 200) begin @(negedge clk); #1; t++; end
      checkOutput("stop_ign0_delay", t, T);
      checkOutput("stop_s1_with_ign0", int'(s1), 1);
      d = 0;
      while (doneCount == 0 && d < 200) begin @(negedge clk); #1; d++; end
      checkOutput("stop_settle_to_done", d, S + 1);
      waitIdle("stop");
      checkOutput("stop_ign0_cleared", int'(ignore0), 0);
      checkOutput("stop_cur_sel", int'(cur_sel), 1);
      checkOutput("stop_done_count", doneCount, 1);
      hb0Run = 1'b1;

      // Reset during ARM, then a normal switch
      repeat (6) @(negedge clk);
      applyStimulus(1'b0);
      n = 0;
      while (!s0 && n < 200) begin @(negedge clk); #1; n++; end
      checkOutput("arm_reached", int'(s0), 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arm_reset_outputs", int'(outVec()), int'(10'b1010001000));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(1'b0);
      waitIdle("after_reset");
      checkOutput("after_reset_done", doneCount, 1);
      checkOutput("after_reset_cur_sel", int'(cur_sel), 0);

      checkOutput("select_overlap", overlapS, 0);
      checkOutput("enable_overlap", overlapCe, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
